// File: rtl/led_truth_checker_pkg.sv
// Shared definitions for the LED truth-table checker: vector geometry and FSM states.
package led_truth_checker_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/led_settle_timer.sv
// Watches the {S,P,V} vector for changes and asserts stable once it has been
// held for SETTLE settle cycles; after a check it waits for a new vector.
module led_settle_timer
  import led_truth_checker_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             arm,
  input  logic             mark,
  input  logic [VEC_W-1:0] vec,
  output logic             stable
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [VEC_W-1:0] prev_vec;
  logic [VEC_W-1:0] last_vec;
  logic [CW-1:0]    cnt;
  logic             blocked;
  logic             changed;

  assign changed = (vec != prev_vec);
  assign stable  = en && !blocked && !changed && (cnt == LAST);

  // blocked holds off counting until the vector moves away from the one just checked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vec <= '0;
      last_vec <= '0;
      blocked  <= 1'b0;
      cnt      <= '0;
    end else begin
      prev_vec <= vec;
      if (arm) begin
        blocked <= 1'b0;
      end else if (mark) begin
        blocked  <= 1'b1;
        last_vec <= vec;
      end else if (en && blocked && (vec != last_vec)) begin
        blocked <= 1'b0;
      end
      if (!en || blocked || changed || stable) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_truth_checker.sv
// Observer for the S/P/V -> LED logic: checks each settled vector against
// EXPECT_TT, tracks pass/fail counts and coverage, flags done at full coverage.
module led_truth_checker
  import led_truth_checker_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECT_TT = 8'b0000_0000,
  parameter int                 SETTLE    = 4,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               S,
  input  logic               P,
  input  logic               V,
  input  logic               LED,
  output logic               busy,
  output logic               done,
  output logic               chk_pulse,
  output logic               chk_fail,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [NUM_VEC-1:0] coverage,
  output logic [VEC_W-1:0]   first_fail_vec,
  output logic               any_fail
);

  state_t             state;
  state_t             next_state;
  logic [VEC_W-1:0]   vec;
  logic [NUM_VEC-1:0] vec_onehot;
  logic [NUM_VEC-1:0] cov_next;
  logic               settle_en;
  logic               check_en;
  logic               stable;
  logic               mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vec       = {S, P, V};
  assign settle_en = (state == ST_SETTLE) && !start;
  assign check_en  = (state == ST_CHECK) && !start;
  assign mismatch  = LED ^ EXPECT_TT[vec];
  assign cov_next  = coverage | vec_onehot;

  always_comb begin
    vec_onehot      = '0;
    vec_onehot[vec] = 1'b1;
  end

  led_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (settle_en),
    .arm    (start),
    .mark   (check_en),
    .vec    (vec),
    .stable (stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // start overrides every other transition, including leaving DONE
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: if (stable) next_state = ST_CHECK;
        ST_CHECK:  next_state = (&cov_next) ? ST_DONE : ST_SETTLE;
        default:   next_state = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_SETTLE) || (state == ST_CHECK);
    done      = (state == ST_DONE);
    chk_pulse = check_en;
    chk_fail  = check_en && mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      coverage       <= '0;
      first_fail_vec <= '0;
      any_fail       <= 1'b0;
    end else if (start) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      coverage       <= '0;
      first_fail_vec <= '0;
      any_fail       <= 1'b0;
    end else if (check_en) begin
      coverage <= cov_next;
      if (mismatch) begin
        fail_cnt <= sat_inc(fail_cnt);
        any_fail <= 1'b1;
        if (!any_fail) first_fail_vec <= vec;
      end else begin
        pass_cnt <= sat_inc(pass_cnt);
      end
    end
  end

endmodule

// File: tb/tb_led_truth_checker.sv
// Bench for led_truth_checker: directed sweeps plus random vectors, checked each
// cycle against a window-based reference model of the settle/check rules.
module tb_led_truth_checker;
  import led_truth_checker_pkg::*;

  localparam logic [7:0] TT    = 8'b1110_1000;
  localparam int         ST    = 4;
  localparam int         NEVER = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst, start, S, P, V, LED;
  logic       busy, done, chk_pulse, chk_fail, any_fail;
  logic [7:0] pass_cnt, fail_cnt, coverage;
  logic [2:0] first_fail_vec;
  logic       busy2, done2, chk_pulse2, chk_fail2, any_fail2;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic [7:0] coverage2;
  logic [2:0] first_fail_vec2;

  always #5 clk = ~clk;

  led_truth_checker #(.EXPECT_TT(TT), .SETTLE(ST), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .S(S), .P(P), .V(V), .LED(LED),
    .busy(busy), .done(done), .chk_pulse(chk_pulse), .chk_fail(chk_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .coverage(coverage),
    .first_fail_vec(first_fail_vec), .any_fail(any_fail)
  );

  led_truth_checker #(.EXPECT_TT(TT), .SETTLE(ST), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .S(S), .P(P), .V(V), .LED(LED),
    .busy(busy2), .done(done2), .chk_pulse(chk_pulse2), .chk_fail(chk_fail2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .coverage(coverage2),
    .first_fail_vec(first_fail_vec2), .any_fail(any_fail2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a vector is checked in cycle t when the last ST+1 sampled
  // vectors (cycles t-ST-1 .. t-1) are identical and the window opened no
  // earlier than arming or the first move away from the previously checked vector.
  int         cyc = 0, open_at = NEVER, passes = 0, fails = 0, npulse = 0;
  bit         armed = 0, finished = 0, blocked = 0, anyf = 0;
  logic [2:0] last_chk = '0, ffv = '0;
  logic [7:0] cov = '0;
  logic [2:0] hist[$];

  always @(negedge clk) begin
    logic [2:0] v;
    bit steady, fire;
    v = {S, P, V};
    if (rst) begin
      armed = 0; finished = 0; blocked = 0; anyf = 0;
      passes = 0; fails = 0; cov = '0; ffv = '0; open_at = NEVER;
      hist.delete();
    end
    steady = (hist.size() == ST + 1);
    foreach (hist[i]) if (hist[i] != hist[0]) steady = 0;
    fire = !rst && armed && !start && (cyc - ST >= open_at) && steady;

    chk_eq("busy", 32'(busy), 32'(armed));
    chk_eq("done", 32'(done), 32'(finished));
    chk_eq("chk_pulse", 32'(chk_pulse), 32'(fire));
    chk_eq("chk_fail", 32'(chk_fail), 32'(fire && (LED != TT[v])));
    chk_eq("pass_cnt", 32'(pass_cnt), 32'(passes > 255 ? 255 : passes));
    chk_eq("fail_cnt", 32'(fail_cnt), 32'(fails > 255 ? 255 : fails));
    chk_eq("coverage", 32'(coverage), 32'(cov));
    chk_eq("first_fail_vec", 32'(first_fail_vec), 32'(ffv));
    chk_eq("any_fail", 32'(any_fail), 32'(anyf));
    chk_eq("pass_cnt_w2", 32'(pass_cnt2), 32'(passes > 3 ? 3 : passes));
    chk_eq("fail_cnt_w2", 32'(fail_cnt2), 32'(fails > 3 ? 3 : fails));
    if (chk_pulse) npulse++;

    if (!rst) begin
      if (start) begin
        armed = 1; finished = 0; blocked = 0; anyf = 0;
        passes = 0; fails = 0; cov = '0; ffv = '0; open_at = cyc + 1;
      end else if (fire) begin
        if (LED != TT[v]) begin
          fails++;
          if (!anyf) ffv = v;
          anyf = 1;
        end else begin
          passes++;
        end
        cov[v] = 1'b1;
        last_chk = v; blocked = 1; open_at = NEVER;
        if (cov == 8'hFF) begin
          armed = 0; finished = 1;
        end
      end else if (armed && blocked && (v != last_chk)) begin
        blocked = 0; open_at = cyc + 1;
      end
      hist.push_back(v);
      if (hist.size() > ST + 1) void'(hist.pop_front());
    end
    cyc++;
  end

  task automatic hold(input logic [2:0] v, input int n, input bit inv);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      {S, P, V} = v;
      LED = TT[v] ^ inv;
      start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic sweep(input logic [7:0] inv_mask);
    for (int k = 0; k < 8; k++) hold(3'(k), 10, inv_mask[k]);
  endtask

  initial begin
    int base;
    int left;
    logic [2:0] cur;
    rst = 1'b1; start = 1'b0; {S, P, V} = 3'd0; LED = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full correct sweep
    base = npulse;
    pulse_start();
    sweep(8'h00);
    @(negedge clk); #1;
    chk_eq("t1_pulses", 32'(npulse - base), 32'd8);
    chk_eq("t1_pass", 32'(pass_cnt), 32'd8);
    chk_eq("t1_fail", 32'(fail_cnt), 32'd0);
    chk_eq("t1_cov", 32'(coverage), 32'hFF);
    chk_eq("t1_done", 32'(done), 32'd1);
    chk_eq("t1_any_fail", 32'(any_fail), 32'd0);
    chk_eq("t1_sat", 32'(pass_cnt2), 32'd3);

    // LED wrong for vectors 3 and 6, then vector changes while done
    base = npulse;
    pulse_start();
    sweep(8'b0100_1000);
    @(negedge clk); #1;
    chk_eq("t2_fail", 32'(fail_cnt), 32'd2);
    chk_eq("t2_pass", 32'(pass_cnt), 32'd6);
    chk_eq("t2_any_fail", 32'(any_fail), 32'd1);
    chk_eq("t2_first_fail", 32'(first_fail_vec), 32'd3);
    chk_eq("t2_sat_pass", 32'(pass_cnt2), 32'd3);
    hold(3'd1, 6, 1'b0); hold(3'd4, 6, 1'b1); hold(3'd2, 6, 1'b0);
    @(negedge clk); #1;
    chk_eq("t2_done_hold", 32'(done), 32'd1);
    chk_eq("t2_frozen_pulses", 32'(npulse - base), 32'd8);
    chk_eq("t2_frozen_pass", 32'(pass_cnt), 32'd6);

    // vector toggling faster than the settle time
    base = npulse;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      hold(3'd1, 2, 1'b0);
      hold(3'd2, 2, 1'b0);
    end
    @(negedge clk); #1;
    chk_eq("t3_pulses", 32'(npulse - base), 32'd0);
    chk_eq("t3_cov", 32'(coverage), 32'd0);
    chk_eq("t3_busy", 32'(busy), 32'd1);

    // long hold is checked once; returning to it is checked again
    base = npulse;
    hold(3'd5, 40, 1'b0);
    @(negedge clk); #1;
    chk_eq("t4_single", 32'(npulse - base), 32'd1);
    hold(3'd2, 10, 1'b0);
    hold(3'd5, 10, 1'b0);
    @(negedge clk); #1;
    chk_eq("t4_pass", 32'(pass_cnt), 32'd3);
    chk_eq("t4_cov", 32'(coverage), 32'h24);

    // asynchronous reset mid-sweep, then start mid-sweep
    pulse_start();
    for (int k = 0; k < 4; k++) hold(3'(k), 10, 1'b0);
    @(negedge clk); #1;
    chk_eq("t5_pre_rst", 32'(pass_cnt), 32'd4);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk_eq("t5_rst_busy", 32'(busy), 32'd0);
    chk_eq("t5_rst_pass", 32'(pass_cnt), 32'd0);
    chk_eq("t5_rst_cov", 32'(coverage), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulse_start();
    for (int k = 0; k < 3; k++) hold(3'(k), 10, 1'b0);
    @(negedge clk); #1;
    chk_eq("t5_mid_pass", 32'(pass_cnt), 32'd3);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk_eq("t5_restart_pass", 32'(pass_cnt), 32'd0);
    chk_eq("t5_restart_cov", 32'(coverage), 32'd0);
    sweep(8'h00);
    @(negedge clk); #1;
    chk_eq("t5_resweep", 32'(pass_cnt), 32'd8);
    chk_eq("t5_done", 32'(done), 32'd1);

    // random vectors, LED errors, occasional start and reset
    pulse_start();
    left = 0;
    cur = '0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (left == 0) begin
        cur  = 3'($urandom_range(0, 7));
        left = $urandom_range(1, 9);
      end
      left--;
      {S, P, V} = cur;
      LED   = TT[cur] ^ ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1; start = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
